rca_config_bank: RTL and testbench
==================================

# rca_config_bank

Double-buffered configuration store for the reconfigurable compute accelerators (RCAs). It extends single-bank RCA config registers with per-RCA shadow and active banks, a valid/ready configuration write stream, and a commit handshake. The commit swaps shadow into active only when the target RCA is idle. It sits between the decode/issue path that streams configuration words and the RCA grid, IO units and result crossbars, which consume the active configuration of the RCA selected by `rca_sel`.

## Interface
Parameters:
- NUM_RCAS, 2: number of RCAs; each has its own shadow and active bank.
- NUM_READ_PORTS, 3: CPU source-register ports per RCA.
- NUM_WRITE_PORTS, 2: CPU destination-register ports per RCA.
- GRID_NUM_ROWS, 4: grid rows; this is also the IO mux count.
- NUM_GRID_MUXES, 16: grid crossbar muxes per RCA.
- GRID_MUX_SEL_W, 3: grid mux select width.
- IO_MUX_SEL_W, 4: IO unit mux select width.
- CFG_DATA_W, 8: config data width; must be ≥ every field width.
- COMMIT_CNT_W, 8: width of the commit counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config write can be accepted.
- cfg_rca  in  clog2(NUM_RCAS)  target RCA.
- cfg_field  in  3  field select: 0 src reg addr, 1 dest reg addr, 2 grid mux, 3 io mux, 4 result mux; 5–7 illegal.
- cfg_index  in  clog2(NUM_GRID_MUXES)  entry index within the field.
- cfg_data  in  CFG_DATA_W  value; the low field-width bits are used.
- cfg_err  out  1  one-cycle pulse: the previous accepted write was dropped.
- commit_valid  in  1  commit request.
- commit_ready  out  1  a commit can be accepted.
- commit_rca  in  clog2(NUM_RCAS)  RCA to commit.
- rca_busy  in  NUM_RCAS  per-RCA busy flags; commit waits while the target's flag is high.
- commit_done  out  1  one-cycle pulse: the active bank has been updated.
- dirty  out  NUM_RCAS  shadow differs from active since the last commit.
- commit_count  out  COMMIT_CNT_W  total completed commits; wraps.
- rca_sel  in  clog2(NUM_RCAS)  selects the active bank driven on the outputs below.
- act_src_addrs  out  5*NUM_READ_PORTS  active source register addresses, port 0 in the LSBs.
- act_dest_addrs  out  5*NUM_WRITE_PORTS  active destination register addresses.
- act_grid_sels  out  GRID_MUX_SEL_W*NUM_GRID_MUXES  active grid mux selects.
- act_io_sels  out  IO_MUX_SEL_W*GRID_NUM_ROWS  active IO mux selects.
- act_result_sels  out  clog2(GRID_NUM_ROWS)*NUM_WRITE_PORTS  active result mux selects.

## Operation
- **Config write.** A write is accepted when cfg_valid && cfg_ready. It writes shadow[cfg_rca].field[cfg_index] and sets dirty[cfg_rca].
- **Dropped writes.** A write is dropped if cfg_field is in 5–7 or cfg_index ≥ the field depth, or if cfg_rca ≥ NUM_RCAS. Field depths are NUM_READ_PORTS, NUM_WRITE_PORTS, NUM_GRID_MUXES, GRID_NUM_ROWS and NUM_WRITE_PORTS respectively. A dropped write is still accepted (handshake completes) but changes no state, and cfg_err pulses on the next cycle.
- **Commit FSM states:** IDLE, WAIT, DONE.
  - IDLE: commit_ready=1. On commit_valid, latch pend_rca=commit_rca and go to WAIT.
  - WAIT: if !rca_busy[pend_rca], copy shadow[pend_rca] to active[pend_rca] on this edge, clear dirty[pend_rca], increment commit_count and go to DONE. Otherwise stay in WAIT indefinitely.
  - DONE: commit_done=1; go to IDLE.
- **cfg_ready.** cfg_ready=0 only when the state is WAIT or DONE and cfg_rca==pend_rca. Writes to other RCAs proceed during a commit.
- **Simultaneous events.**
  - A write to RCA r accepted in the same cycle that a commit of r is accepted lands in shadow before the copy and is included in the commit.
  - A commit while dirty=0 still copies, pulses commit_done and counts.
- **Active outputs.** These are combinational from active[rca_sel]. rca_sel ≥ NUM_RCAS drives all zeros. Shadow contents are never visible on the outputs.
- **Reset.** Reset zeroes all shadow and active entries, dirty, commit_count and cfg_err, and sets state to IDLE. A reset during WAIT or DONE aborts the commit; no commit_done is produced.

## Timing
- **Reset values.** After a reset edge: cfg_ready=1, commit_ready=1, commit_done=0, cfg_err=0, dirty=0, commit_count=0, all act_* outputs 0.
- **Shadow write latency.** A write accepted at edge N is in shadow from N+1; cfg_err, when raised, is high in cycle N+1 only.
- **Commit latency.** Accept at edge N; copy at edge N+1 at the earliest (rca_busy low in cycle N+1); commit_done high during cycle N+2−, i.e. the cycle after the copy edge. The active outputs show new values in the same cycle commit_done is high.
- **Commit throughput.** Minimum commit-to-commit spacing is 3 cycles: IDLE→WAIT→DONE→IDLE. commit_ready is low in WAIT and DONE.
- **Busy while waiting.** If rca_busy[pend_rca] rises while in WAIT, the copy is held off until it falls.
- **Counter wrap.** commit_count wraps from 2^COMMIT_CNT_W−1 to 0.

## Test plan
- **Write then commit.** Reset; write rca 1, field 2, index 5, data 6; then commit rca 1 with busy=0. Required: act_grid_sels[17:15]=6 when rca_sel=1, only after commit_done; dirty[1] goes 1 then 0; commit_count=1.
- **Commit blocked by busy.** Hold rca_busy[0]=1 for 10 cycles after accepting a commit of rca 0. Required: no copy and no commit_done for 10 cycles; cfg_ready=0 for rca 0 and 1 for rca 1; copy on the first edge where busy is low.
- **Illegal writes.** Write with field 6, and separately field 0 with index 3 (NUM_READ_PORTS=3). Required: cfg_err pulses once per write; shadow, dirty and outputs unchanged.
- **Same-cycle write and commit.** Write rca 0 field 0 index 1 data 9 in the same cycle a commit of rca 0 is accepted. Required: act_src_addrs[9:5]=9 after commit_done.
- **Reset mid-commit.** Assert rst during WAIT. Required: state returns to IDLE, no commit_done, all act_* outputs=0, commit_count=0.
- **Counter wrap.** Perform 256 commits with COMMIT_CNT_W=8. Required: commit_count=0 and each commit_done is a single-cycle pulse.

Source files
------------

// File: rtl/rca_config_bank.sv
// Double-buffered RCA configuration store.
// Writes land in a per-RCA shadow bank; a commit copies one RCA's shadow
// into its active bank once that RCA is idle. Consumers see only the active
// bank of the RCA selected by rca_sel.
module rca_config_bank #(
  parameter int NUM_RCAS        = 2,
  parameter int NUM_READ_PORTS  = 3,
  parameter int NUM_WRITE_PORTS = 2,
  parameter int GRID_NUM_ROWS   = 4,
  parameter int NUM_GRID_MUXES  = 16,
  parameter int GRID_MUX_SEL_W  = 3,
  parameter int IO_MUX_SEL_W    = 4,
  parameter int CFG_DATA_W      = 8,
  parameter int COMMIT_CNT_W    = 8,
  localparam int RCA_W = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1,
  localparam int IDX_W = (NUM_GRID_MUXES > 1) ? $clog2(NUM_GRID_MUXES) : 1,
  localparam int RES_W = (GRID_NUM_ROWS > 1) ? $clog2(GRID_NUM_ROWS) : 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    cfg_valid,
  output logic                                    cfg_ready,
  input  logic [RCA_W-1:0]                        cfg_rca,
  input  logic [2:0]                              cfg_field,
  input  logic [IDX_W-1:0]                        cfg_index,
  input  logic [CFG_DATA_W-1:0]                   cfg_data,
  output logic                                    cfg_err,
  input  logic                                    commit_valid,
  output logic                                    commit_ready,
  input  logic [RCA_W-1:0]                        commit_rca,
  input  logic [NUM_RCAS-1:0]                     rca_busy,
  output logic                                    commit_done,
  output logic [NUM_RCAS-1:0]                     dirty,
  output logic [COMMIT_CNT_W-1:0]                 commit_count,
  input  logic [RCA_W-1:0]                        rca_sel,
  output logic [5*NUM_READ_PORTS-1:0]             act_src_addrs,
  output logic [5*NUM_WRITE_PORTS-1:0]            act_dest_addrs,
  output logic [GRID_MUX_SEL_W*NUM_GRID_MUXES-1:0] act_grid_sels,
  output logic [IO_MUX_SEL_W*GRID_NUM_ROWS-1:0]   act_io_sels,
  output logic [RES_W*NUM_WRITE_PORTS-1:0]        act_result_sels
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t state_reg, state_next;
  logic [RCA_W-1:0]        pend_rca_reg;
  logic [NUM_RCAS-1:0]     dirty_reg;
  logic [COMMIT_CNT_W-1:0] commit_count_reg;
  logic                    cfg_err_reg;

  // Shadow and active banks, one entry per field slot.
  logic [4:0]                sh_src_reg  [NUM_RCAS][NUM_READ_PORTS];
  logic [4:0]                sh_dest_reg [NUM_RCAS][NUM_WRITE_PORTS];
  logic [GRID_MUX_SEL_W-1:0] sh_grid_reg [NUM_RCAS][NUM_GRID_MUXES];
  logic [IO_MUX_SEL_W-1:0]   sh_io_reg   [NUM_RCAS][GRID_NUM_ROWS];
  logic [RES_W-1:0]          sh_res_reg  [NUM_RCAS][NUM_WRITE_PORTS];
  logic [4:0]                ac_src_reg  [NUM_RCAS][NUM_READ_PORTS];
  logic [4:0]                ac_dest_reg [NUM_RCAS][NUM_WRITE_PORTS];
  logic [GRID_MUX_SEL_W-1:0] ac_grid_reg [NUM_RCAS][NUM_GRID_MUXES];
  logic [IO_MUX_SEL_W-1:0]   ac_io_reg   [NUM_RCAS][GRID_NUM_ROWS];
  logic [RES_W-1:0]          ac_res_reg  [NUM_RCAS][NUM_WRITE_PORTS];

  logic cfg_accept, cfg_legal, pend_busy, copy_en;
  int   field_depth;

  assign cfg_accept = cfg_valid && cfg_ready;
  assign copy_en    = (state_reg == ST_WAIT) && !pend_busy;

  // Legality of the presented write: known field, index inside its depth, real RCA.
  always_comb begin
    field_depth = 0;
    case (cfg_field)
      3'd0:    field_depth = NUM_READ_PORTS;
      3'd1:    field_depth = NUM_WRITE_PORTS;
      3'd2:    field_depth = NUM_GRID_MUXES;
      3'd3:    field_depth = GRID_NUM_ROWS;
      3'd4:    field_depth = NUM_WRITE_PORTS;
      default: field_depth = 0;
    endcase
    cfg_legal = (int'(cfg_rca) < NUM_RCAS) && (int'(cfg_index) < field_depth);
  end

  // Busy flag of the RCA being committed; an out-of-range target never blocks.
  always_comb begin
    pend_busy = 1'b0;
    for (int r = 0; r < NUM_RCAS; r++)
      if (int'(pend_rca_reg) == r) pend_busy = rca_busy[r];
  end

  // Commit FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Commit FSM next state: WAIT holds for as long as the target reports busy.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (commit_valid) state_next = ST_WAIT;
      ST_WAIT: if (!pend_busy)   state_next = ST_DONE;
      ST_DONE:                   state_next = ST_IDLE;
      default:                   state_next = ST_IDLE;
    endcase
  end

  // Commit FSM outputs; only writes to the RCA being committed are stalled.
  always_comb begin
    commit_ready = (state_reg == ST_IDLE);
    commit_done  = (state_reg == ST_DONE);
    cfg_ready    = !((state_reg != ST_IDLE) && (cfg_rca == pend_rca_reg));
  end

  // Pending target, dirty flags, commit counter and dropped-write pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_rca_reg     <= '0;
      dirty_reg        <= '0;
      commit_count_reg <= '0;
      cfg_err_reg      <= 1'b0;
    end else begin
      cfg_err_reg <= cfg_accept && !cfg_legal;
      if (state_reg == ST_IDLE && commit_valid) pend_rca_reg <= commit_rca;
      if (copy_en) commit_count_reg <= commit_count_reg + COMMIT_CNT_W'(1);
      for (int r = 0; r < NUM_RCAS; r++) begin
        if (copy_en && int'(pend_rca_reg) == r) dirty_reg[r] <= 1'b0;
        if (cfg_accept && cfg_legal && int'(cfg_rca) == r) dirty_reg[r] <= 1'b1;
      end
    end
  end

  // Shadow bank writes; dropped writes never reach here.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_RCAS; r++) begin
      if (rst) begin
        for (int i = 0; i < NUM_READ_PORTS; i++)  sh_src_reg[r][i]  <= '0;
        for (int i = 0; i < NUM_WRITE_PORTS; i++) sh_dest_reg[r][i] <= '0;
        for (int i = 0; i < NUM_GRID_MUXES; i++)  sh_grid_reg[r][i] <= '0;
        for (int i = 0; i < GRID_NUM_ROWS; i++)   sh_io_reg[r][i]   <= '0;
        for (int i = 0; i < NUM_WRITE_PORTS; i++) sh_res_reg[r][i]  <= '0;
      end else if (cfg_accept && cfg_legal && int'(cfg_rca) == r) begin
        for (int i = 0; i < NUM_READ_PORTS; i++)
          if (cfg_field == 3'd0 && int'(cfg_index) == i) sh_src_reg[r][i] <= cfg_data[4:0];
        for (int i = 0; i < NUM_WRITE_PORTS; i++)
          if (cfg_field == 3'd1 && int'(cfg_index) == i) sh_dest_reg[r][i] <= cfg_data[4:0];
        for (int i = 0; i < NUM_GRID_MUXES; i++)
          if (cfg_field == 3'd2 && int'(cfg_index) == i) sh_grid_reg[r][i] <= cfg_data[GRID_MUX_SEL_W-1:0];
        for (int i = 0; i < GRID_NUM_ROWS; i++)
          if (cfg_field == 3'd3 && int'(cfg_index) == i) sh_io_reg[r][i] <= cfg_data[IO_MUX_SEL_W-1:0];
        for (int i = 0; i < NUM_WRITE_PORTS; i++)
          if (cfg_field == 3'd4 && int'(cfg_index) == i) sh_res_reg[r][i] <= cfg_data[RES_W-1:0];
      end
    end
  end

  // Active bank: whole-RCA copy from shadow on the commit edge.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_RCAS; r++) begin
      if (rst) begin
        for (int i = 0; i < NUM_READ_PORTS; i++)  ac_src_reg[r][i]  <= '0;
        for (int i = 0; i < NUM_WRITE_PORTS; i++) ac_dest_reg[r][i] <= '0;
        for (int i = 0; i < NUM_GRID_MUXES; i++)  ac_grid_reg[r][i] <= '0;
        for (int i = 0; i < GRID_NUM_ROWS; i++)   ac_io_reg[r][i]   <= '0;
        for (int i = 0; i < NUM_WRITE_PORTS; i++) ac_res_reg[r][i]  <= '0;
      end else if (copy_en && int'(pend_rca_reg) == r) begin
        ac_src_reg[r]  <= sh_src_reg[r];
        ac_dest_reg[r] <= sh_dest_reg[r];
        ac_grid_reg[r] <= sh_grid_reg[r];
        ac_io_reg[r]   <= sh_io_reg[r];
        ac_res_reg[r]  <= sh_res_reg[r];
      end
    end
  end

  // Drive the selected RCA's active bank; an unknown selection reads as zero.
  always_comb begin
    act_src_addrs   = '0;
    act_dest_addrs  = '0;
    act_grid_sels   = '0;
    act_io_sels     = '0;
    act_result_sels = '0;
    for (int r = 0; r < NUM_RCAS; r++) begin
      if (int'(rca_sel) == r) begin
        for (int i = 0; i < NUM_READ_PORTS; i++)  act_src_addrs[i*5 +: 5]  = ac_src_reg[r][i];
        for (int i = 0; i < NUM_WRITE_PORTS; i++) act_dest_addrs[i*5 +: 5] = ac_dest_reg[r][i];
        for (int i = 0; i < NUM_GRID_MUXES; i++)
          act_grid_sels[i*GRID_MUX_SEL_W +: GRID_MUX_SEL_W] = ac_grid_reg[r][i];
        for (int i = 0; i < GRID_NUM_ROWS; i++)
          act_io_sels[i*IO_MUX_SEL_W +: IO_MUX_SEL_W] = ac_io_reg[r][i];
        for (int i = 0; i < NUM_WRITE_PORTS; i++)
          act_result_sels[i*RES_W +: RES_W] = ac_res_reg[r][i];
      end
    end
  end

  assign dirty        = dirty_reg;
  assign commit_count = commit_count_reg;
  assign cfg_err      = cfg_err_reg;

endmodule

// File: tb/tb_rca_config_bank.sv
// Self-checking bench for rca_config_bank: table-driven writes, hand-written
// commit sequences, and random traffic against a bank-level reference model.
module tb_rca_config_bank;

  logic        clk, rst;
  logic        cfg_valid, cfg_ready, cfg_err;
  logic [0:0]  cfg_rca;
  logic [2:0]  cfg_field;
  logic [3:0]  cfg_index;
  logic [7:0]  cfg_data;
  logic        commit_valid, commit_ready, commit_done;
  logic [0:0]  commit_rca;
  logic [1:0]  rca_busy, dirty;
  logic [7:0]  commit_count;
  logic [0:0]  rca_sel;
  logic [14:0] act_src_addrs;
  logic [9:0]  act_dest_addrs;
  logic [47:0] act_grid_sels;
  logic [15:0] act_io_sels;
  logic [3:0]  act_result_sels;

  rca_config_bank dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_rca(cfg_rca),
    .cfg_field(cfg_field), .cfg_index(cfg_index), .cfg_data(cfg_data),
    .cfg_err(cfg_err),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_rca(commit_rca), .rca_busy(rca_busy), .commit_done(commit_done),
    .dirty(dirty), .commit_count(commit_count), .rca_sel(rca_sel),
    .act_src_addrs(act_src_addrs), .act_dest_addrs(act_dest_addrs),
    .act_grid_sels(act_grid_sels), .act_io_sels(act_io_sels),
    .act_result_sels(act_result_sels)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: banks as plain integer tables [rca][field][index].
  int m_sh [2][5][16];
  int m_act[2][5][16];
  bit [1:0] m_dirty;
  int m_cnt;
  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    int rca; int field; int idx; int data; bit exp_err;
  } wr_vec_t;
  wr_vec_t tbl[12];

  function automatic int fdepth(int f);
    case (f)
      0: return 3;  1: return 2;  2: return 16;  3: return 4;  4: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int fwidth(int f);
    case (f)
      0: return 5;  1: return 5;  2: return 3;  3: return 4;  4: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic bit m_legal(int r, int f, int i);
    return (r < 2) && (f < 5) && (i < fdepth(f));
  endfunction

  function automatic void m_write(int r, int f, int i, int d);
    if (m_legal(r, f, i)) begin
      m_sh[r][f][i] = d % (1 << fwidth(f));
      m_dirty[r] = 1'b1;
    end
  endfunction

  function automatic void m_commit(int r);
    m_act[r] = m_sh[r];
    m_dirty[r] = 1'b0;
    m_cnt = (m_cnt + 1) % 256;
  endfunction

  function automatic void m_reset();
    for (int r = 0; r < 2; r++)
      for (int f = 0; f < 5; f++)
        for (int i = 0; i < 16; i++) begin
          m_sh[r][f][i] = 0;
          m_act[r][f][i] = 0;
        end
    m_dirty = '0;
    m_cnt = 0;
  endfunction

  // Expected packed output: entry i occupies bits [w*i +: w].
  function automatic longint exp_pack(int s, int f);
    longint v = 0;
    for (int i = 0; i < fdepth(f); i++)
      v = v + longint'(m_act[s][f][i]) * (longint'(1) << (fwidth(f) * i));
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare status and both RCAs' active outputs with the model.
  task automatic check_state(input string tag);
    chk({tag, "_dirty"}, 64'(dirty), 64'(m_dirty));
    chk({tag, "_count"}, 64'(commit_count), 64'(m_cnt));
    for (int s = 0; s < 2; s++) begin
      rca_sel = 1'(s);
      #1;
      chk({tag, "_src"},  64'(act_src_addrs),   64'(exp_pack(s, 0)));
      chk({tag, "_dest"}, 64'(act_dest_addrs),  64'(exp_pack(s, 1)));
      chk({tag, "_grid"}, 64'(act_grid_sels),   64'(exp_pack(s, 2)));
      chk({tag, "_io"},   64'(act_io_sels),     64'(exp_pack(s, 3)));
      chk({tag, "_res"},  64'(act_result_sels), 64'(exp_pack(s, 4)));
    end
  endtask

  task automatic do_write(input int r, input int f, input int i, input int d, input bit exp_err);
    cfg_valid = 1'b1; cfg_rca = 1'(r); cfg_field = 3'(f);
    cfg_index = 4'(i); cfg_data = 8'(d);
    chk("wr_ready", 64'(cfg_ready), 64'd1);
    step();
    cfg_valid = 1'b0;
    m_write(r, f, i, d);
    chk("wr_err", 64'(cfg_err), 64'(exp_err));
    $display("write rca=%0d field=%0d idx=%0d data=%0d err=%0d", r, f, i, d, cfg_err);
    check_state("wr");
    step();
    chk("wr_err_pulse", 64'(cfg_err), 64'd0);
  endtask

  // Commit r, holding its busy flag for `busy` cycles; optional same-cycle write to r.
  task automatic do_commit(input int r, input int busy, input bit wr,
                           input int wf, input int wi, input int wd);
    commit_valid = 1'b1; commit_rca = 1'(r);
    rca_busy = '0;
    if (busy > 0) rca_busy[r] = 1'b1;
    chk("cm_ready_idle", 64'(commit_ready), 64'd1);
    if (wr) begin
      cfg_valid = 1'b1; cfg_rca = 1'(r); cfg_field = 3'(wf);
      cfg_index = 4'(wi); cfg_data = 8'(wd);
    end
    step();
    commit_valid = 1'b0; cfg_valid = 1'b0;
    if (wr) m_write(r, wf, wi, wd);
    for (int k = 0; k < busy; k++) begin
      chk("busy_no_done", 64'(commit_done), 64'd0);
      chk("busy_cm_ready", 64'(commit_ready), 64'd0);
      cfg_rca = 1'(r);
      #1 chk("busy_cfg_ready_same", 64'(cfg_ready), 64'd0);
      cfg_rca = 1'(1 - r);
      #1 chk("busy_cfg_ready_other", 64'(cfg_ready), 64'd1);
      check_state("busy");
      step();
    end
    rca_busy = '0;
    step();
    m_commit(r);
    chk("cm_done", 64'(commit_done), 64'd1);
    chk("cm_ready_done", 64'(commit_ready), 64'd0);
    $display("commit rca=%0d busy=%0d done=%0d count=%0d", r, busy, commit_done, commit_count);
    check_state("cm");
    step();
    chk("cm_done_pulse", 64'(commit_done), 64'd0);
    chk("cm_ready_back", 64'(commit_ready), 64'd1);
  endtask

  initial begin
    tbl[0]  = '{1, 2, 5, 6, 0};
    tbl[1]  = '{0, 0, 1, 7, 0};
    tbl[2]  = '{0, 6, 0, 3, 1};
    tbl[3]  = '{0, 0, 3, 9, 1};
    tbl[4]  = '{1, 1, 1, 31, 0};
    tbl[5]  = '{1, 3, 3, 15, 0};
    tbl[6]  = '{1, 4, 1, 3, 0};
    tbl[7]  = '{0, 4, 2, 1, 1};
    tbl[8]  = '{1, 7, 0, 0, 1};
    tbl[9]  = '{0, 2, 15, 5, 0};
    tbl[10] = '{1, 1, 2, 1, 1};
    tbl[11] = '{0, 3, 4, 2, 1};

    rst = 1'b1; cfg_valid = 1'b0; cfg_rca = '0; cfg_field = '0; cfg_index = '0;
    cfg_data = '0; commit_valid = 1'b0; commit_rca = '0; rca_busy = '0; rca_sel = '0;
    m_reset();
    step(); step();
    rst = 1'b0;
    chk("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    chk("rst_commit_ready", 64'(commit_ready), 64'd1);
    chk("rst_commit_done", 64'(commit_done), 64'd0);
    chk("rst_cfg_err", 64'(cfg_err), 64'd0);
    check_state("rst");

    // Illegal writes first: nothing may change.
    do_write(0, 6, 0, 3, 1);
    do_write(0, 0, 3, 9, 1);

    // Table of writes; outputs must stay at the (still zero) active bank.
    for (int t = 0; t < 12; t++)
      do_write(tbl[t].rca, tbl[t].field, tbl[t].idx, tbl[t].data, tbl[t].exp_err);
    chk("plan_dirty1_set", 64'(dirty[1]), 64'd1);

    // Write then commit RCA 1.
    do_commit(1, 0, 0, 0, 0, 0);
    rca_sel = 1'b1;
    #1 chk("plan_grid5", 64'(act_grid_sels[17:15]), 64'd6);
    chk("plan_dirty1_clr", 64'(dirty[1]), 64'd0);
    chk("plan_count1", 64'(commit_count), 64'd1);

    // Commit held off by busy for 10 cycles.
    do_write(0, 1, 0, 17, 0);
    do_commit(0, 10, 0, 0, 0, 0);

    // Same-cycle write and commit of RCA 0.
    do_commit(0, 0, 1, 0, 1, 9);
    rca_sel = 1'b0;
    #1 chk("same_cycle_src1", 64'(act_src_addrs[9:5]), 64'd9);

    // Random traffic.
    for (int n = 0; n < 150; n++) begin
      int op, r, f, i, d;
      op = $urandom_range(0, 3);
      r = $urandom_range(0, 1); f = $urandom_range(0, 7);
      i = $urandom_range(0, 15); d = $urandom_range(0, 255);
      if (op <= 1)      do_write(r, f, i, d, !m_legal(r, f, i));
      else if (op == 2) do_commit(r, $urandom_range(0, 3), 1'($urandom_range(0, 1)), f, i, d);
      else begin
        step();
        check_state("idle");
      end
    end

    // Reset during WAIT aborts the commit.
    do_write(1, 0, 0, 4, 0);
    do_commit(1, 0, 0, 0, 0, 0);
    commit_valid = 1'b1; commit_rca = 1'b0; rca_busy = 2'b01;
    step();
    commit_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0; rca_busy = '0;
    m_reset();
    chk("mid_rst_done", 64'(commit_done), 64'd0);
    chk("mid_rst_ready", 64'(commit_ready), 64'd1);
    check_state("mid_rst");
    for (int k = 0; k < 3; k++) begin
      step();
      chk("mid_rst_no_done", 64'(commit_done), 64'd0);
    end
    $display("reset mid-commit count=%0d done=%0d", commit_count, commit_done);

    // 256 commits wrap the counter back to zero.
    for (int k = 0; k < 256; k++) do_commit(k % 2, 0, 0, 0, 0, 0);
    chk("wrap_count", 64'(commit_count), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
